// File: rtl/key_pio_pkg.sv
// Shared constants for the debounced key PIO: register offsets and the
// debounce-length calculation used to size the per-key counters.
package key_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

    // Below two cycles the counter could not tell a glitch from a change.
    function automatic int unsigned db_cycles(input int unsigned clk_hz,
                                              input int unsigned debounce_us);
        int unsigned c;
        c = (clk_hz / 1000000) * debounce_us;
        return (c < 2) ? 2 : c;
    endfunction

endpackage

// File: rtl/key_debounce_channel.sv
// One key: synchroniser, consecutive-sample debounce counter, stable level,
// and one-cycle press/release pulses that follow each accepted change.
module key_debounce_channel #(
    parameter int unsigned DB_CYCLES   = 2,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic pressed,
    output logic press_evt,
    output logic release_evt
);

    localparam int unsigned      CNT_W    = $clog2(DB_CYCLES + 1);
    localparam logic             IDLE_LVL = ACTIVE_LOW;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   press_evt_q, press_evt_d;
    logic                   release_evt_q, release_evt_d;
    logic                   synced;

    assign synced = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], key_raw};
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (synced == stable_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = synced;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_evt_d   = (stable_d != stable_q) && (stable_d != IDLE_LVL);
        release_evt_d = (stable_d != stable_q) && (stable_d == IDLE_LVL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= {SYNC_STAGES{IDLE_LVL}};
            cnt_q         <= '0;
            stable_q      <= IDLE_LVL;
            press_evt_q   <= 1'b0;
            release_evt_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            press_evt_q   <= press_evt_d;
            release_evt_q <= release_evt_d;
        end
    end

    assign pressed     = stable_q ^ IDLE_LVL;
    assign press_evt   = press_evt_q;
    assign release_evt = release_evt_q;

endmodule

// File: rtl/key_debounce_pio.sv
// Debounced pushbutton PIO: N key channels behind an Avalon-MM slave with
// edge capture, per-key edge mode, IRQ mask and a level interrupt.
module key_debounce_pio #(
    parameter int unsigned N_KEYS      = 4,
    parameter int unsigned CLK_HZ      = 50000000,
    parameter int unsigned DEBOUNCE_US = 10000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic              CLOCK_50,
    input  logic              RESET_N,
    input  logic [N_KEYS-1:0] KEY_IN,
    input  logic [1:0]        avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              irq,
    output logic [N_KEYS-1:0] key_pressed
);

    import key_pio_pkg::*;

    localparam int unsigned DB_CYCLES = db_cycles(CLK_HZ, DEBOUNCE_US);

    logic [N_KEYS-1:0] press_evt, release_evt, evt;
    logic [N_KEYS-1:0] irq_mask_q, irq_mask_d;
    logic [N_KEYS-1:0] edge_cap_q, edge_cap_d;
    logic [N_KEYS-1:0] edge_sel_q, edge_sel_d;
    logic [31:0]       readdata_q, readdata_d;
    logic [N_KEYS-1:0] wr_bits, w1c;
    logic [31:0]       rd_word;
    logic              wdata_unused;

    for (genvar i = 0; i < N_KEYS; i++) begin : g_chan
        key_debounce_channel #(
            .DB_CYCLES  (DB_CYCLES),
            .SYNC_STAGES(SYNC_STAGES),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_chan (
            .clk        (CLOCK_50),
            .rst_n      (RESET_N),
            .key_raw    (KEY_IN[i]),
            .pressed    (key_pressed[i]),
            .press_evt  (press_evt[i]),
            .release_evt(release_evt[i])
        );
    end

    // EDGE_SEL bit clear: press only; set: press and release.
    assign evt          = press_evt | (release_evt & edge_sel_q);
    assign wr_bits      = avs_writedata[N_KEYS-1:0];
    assign wdata_unused = ^{1'b0, avs_writedata};

    always_comb begin
        irq_mask_d = irq_mask_q;
        edge_sel_d = edge_sel_q;
        w1c        = '0;
        if (avs_write) begin
            case (avs_address)
                ADDR_IRQ_MASK: irq_mask_d = wr_bits;
                ADDR_EDGE_CAP: w1c        = wr_bits;
                ADDR_EDGE_SEL: edge_sel_d = wr_bits;
                default:       ;
            endcase
        end
        // A new event wins over a clear landing in the same cycle.
        edge_cap_d = (edge_cap_q & ~w1c) | evt;
    end

    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA:     rd_word[N_KEYS-1:0] = key_pressed;
            ADDR_IRQ_MASK: rd_word[N_KEYS-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: rd_word[N_KEYS-1:0] = edge_cap_q;
            default:       rd_word[N_KEYS-1:0] = edge_sel_q;
        endcase
        readdata_d = avs_read ? rd_word : readdata_q;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            edge_sel_q <= '0;
            readdata_q <= '0;
        end else begin
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            edge_sel_q <= edge_sel_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs_readdata = readdata_q;
    assign irq          = |(edge_cap_q & irq_mask_q);

endmodule
